// File: rtl/uart_rx_os_fifo.sv
// Oversampled UART receiver with majority-voted bit recovery, runtime frame format,
// break detection, and a first-word-fall-through FIFO carrying per-entry error flags.
module uart_rx_os_fifo #(
  parameter int MAX_DATA_BITS = 9,
  parameter int OVERSAMPLE    = 16,
  parameter int FIFO_DEPTH    = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          sample_tick,
  input  logic [3:0]                    cfg_data_bits,
  input  logic                          cfg_parity_en,
  input  logic                          cfg_parity_odd,
  input  logic                          cfg_stop2,
  input  logic                          rd_en,
  input  logic                          err_clr,
  output logic                          rd_valid,
  output logic [MAX_DATA_BITS-1:0]      rd_data,
  output logic                          rd_perr,
  output logic                          rd_ferr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          break_det,
  output logic [7:0]                    perr_cnt,
  output logic [7:0]                    ferr_cnt,
  output logic [7:0]                    ovf_cnt
);

  localparam int M  = OVERSAMPLE / 2;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(MAX_DATA_BITS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = MAX_DATA_BITS + 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT} state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [BW-1:0] clamp_bits(input logic [3:0] b);
    if (int'(b) < 5) return BW'(5);
    if (int'(b) > MAX_DATA_BITS) return BW'(MAX_DATA_BITS);
    return BW'(b);
  endfunction

  state_t                   state, state_n;
  logic [SYNC_STAGES-1:0]   sync;
  logic                     rxs;
  logic [SW-1:0]            scnt;
  logic [BW-1:0]            bit_idx, nbits;
  logic                     par_en, par_odd, stop2;
  logic                     smp_a, smp_b, pbit, ferr_f;
  logic [MAX_DATA_BITS-1:0] shreg;
  logic                     tick_start, wrap, decide, vote, all_zero;
  logic                     perr_now, ferr_now, frame_done, brk_hit;
  logic                     vld_p0;
  logic [EW-1:0]            frame_p0;

  logic [EW-1:0]            mem [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic [CW-1:0]            count;
  logic                     full, pop, push, drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '1;
    else     sync <= {sync[SYNC_STAGES-2:0], rx};
  end
  assign rxs = sync[SYNC_STAGES-1];

  assign tick_start = sample_tick && (state == IDLE) && !rxs;
  assign wrap       = sample_tick && (scnt == SW'(OVERSAMPLE - 1));
  assign decide     = sample_tick && (scnt == SW'(M + 1));
  assign vote       = (smp_a & smp_b) | (smp_a & rxs) | (smp_b & rxs);
  assign all_zero   = (shreg == '0) && (!par_en || !pbit);
  assign perr_now   = par_en && ((^shreg ^ pbit) != par_odd);
  assign ferr_now   = (state == STOP2) ? (ferr_f | ~vote) : ~vote;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    frame_done = 1'b0;
    brk_hit    = 1'b0;
    case (state)
      IDLE:     if (tick_start) state_n = START;
      START: begin
        if (decide && vote) state_n = IDLE;
        else if (wrap)      state_n = DATA;
      end
      DATA:     if (wrap && bit_idx == nbits - BW'(1)) state_n = par_en ? PARITY : STOP1;
      PARITY:   if (wrap) state_n = STOP1;
      STOP1: begin
        if (decide) begin
          if (!vote && all_zero) begin
            state_n = BRK_WAIT;
            brk_hit = 1'b1;
          end else if (!stop2) begin
            // Leave mid stop bit so the next start edge is caught with half a bit of slack.
            state_n    = IDLE;
            frame_done = 1'b1;
          end
        end else if (wrap && stop2) begin
          state_n = STOP2;
        end
      end
      STOP2: begin
        if (decide) begin
          state_n    = IDLE;
          frame_done = 1'b1;
        end
      end
      BRK_WAIT: if (sample_tick && rxs) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt      <= '0;
      bit_idx   <= '0;
      nbits     <= '0;
      par_en    <= 1'b0;
      par_odd   <= 1'b0;
      stop2     <= 1'b0;
      vld_p0    <= 1'b0;
      break_det <= 1'b0;
    end else begin
      vld_p0    <= frame_done;
      break_det <= brk_hit;
      if (tick_start) begin
        scnt    <= SW'(1);
        bit_idx <= '0;
        nbits   <= clamp_bits(cfg_data_bits);
        par_en  <= cfg_parity_en;
        par_odd <= cfg_parity_odd;
        stop2   <= cfg_stop2;
      end else if (sample_tick && state != IDLE) begin
        scnt <= wrap ? '0 : scnt + SW'(1);
      end
      if (state == DATA && wrap) bit_idx <= bit_idx + BW'(1);
    end
  end

  // Stage p0: completed frame captured with its flags, pushed on the following edge.
  always_ff @(posedge clk) begin
    if (tick_start) shreg <= '0;
    if (sample_tick && scnt == SW'(M - 1)) smp_a <= rxs;
    if (sample_tick && scnt == SW'(M))     smp_b <= rxs;
    if (decide) begin
      case (state)
        DATA:    shreg[bit_idx] <= vote;
        PARITY:  pbit           <= vote;
        STOP1:   ferr_f         <= ~vote;
        default: ;
      endcase
    end
    if (frame_done) frame_p0 <= {ferr_now, perr_now, shreg};
  end

  assign full = (count == CW'(FIFO_DEPTH));
  assign pop  = rd_en && rd_valid;
  assign push = vld_p0 && (!full || pop);
  assign drop = vld_p0 && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= frame_p0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      perr_cnt <= '0;
      ferr_cnt <= '0;
      ovf_cnt  <= '0;
    end else begin
      overflow <= drop;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (err_clr) begin
        perr_cnt <= '0;
        ferr_cnt <= '0;
        ovf_cnt  <= '0;
      end else begin
        if (vld_p0 && frame_p0[EW-2]) perr_cnt <= sat_inc(perr_cnt);
        if (vld_p0 && frame_p0[EW-1]) ferr_cnt <= sat_inc(ferr_cnt);
        if (drop)                     ovf_cnt  <= sat_inc(ovf_cnt);
      end
    end
  end

  assign rd_valid   = (count != '0);
  assign rd_data    = rd_valid ? mem[rd_ptr][MAX_DATA_BITS-1:0] : '0;
  assign rd_perr    = rd_valid && mem[rd_ptr][EW-2];
  assign rd_ferr    = rd_valid && mem[rd_ptr][EW-1];
  assign fifo_count = count;

endmodule

// File: tb/tb_uart_rx_os_fifo.sv
// Bench for uart_rx_os_fifo: directed frames, expected entries queued at send time and
// compared by an independent monitor whenever the FIFO head is popped.
`timescale 1ns/1ps
module tb_uart_rx_os_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       sample_tick;
  logic [3:0] cfg_data_bits;
  logic       cfg_parity_en, cfg_parity_odd, cfg_stop2;
  logic       rd_en = 1'b0;
  logic       err_clr;
  logic       rd_valid;
  logic [8:0] rd_data;
  logic       rd_perr, rd_ferr;
  logic [4:0] fifo_count;
  logic       overflow, break_det;
  logic [7:0] perr_cnt, ferr_cnt, ovf_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [10:0] exp_q[$];
  logic [10:0] mon_exp;
  bit          auto_read = 1'b0;
  bit          man_rd = 1'b0;
  int          ovf_pulses = 0;
  int          brk_pulses = 0;
  int          base;

  uart_rx_os_fifo #(.MAX_DATA_BITS(9), .OVERSAMPLE(16), .FIFO_DEPTH(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .rx(rx), .sample_tick(sample_tick),
    .cfg_data_bits(cfg_data_bits), .cfg_parity_en(cfg_parity_en),
    .cfg_parity_odd(cfg_parity_odd), .cfg_stop2(cfg_stop2),
    .rd_en(rd_en), .err_clr(err_clr), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_perr(rd_perr), .rd_ferr(rd_ferr), .fifo_count(fifo_count),
    .overflow(overflow), .break_det(break_det),
    .perr_cnt(perr_cnt), .ferr_cnt(ferr_cnt), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    sample_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    #1;
    rd_en = auto_read ? rd_valid : man_rd;
  end

  always @(negedge clk) begin
    #2;
    if (rd_en && rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_entry: got %0h expected none", {rd_ferr, rd_perr, rd_data});
      end else begin
        mon_exp = exp_q.pop_front();
        chk("fifo_entry", {rd_ferr, rd_perr, rd_data}, mon_exp);
      end
    end
  end

  always @(negedge clk) begin
    if (overflow === 1'b1)  ovf_pulses++;
    if (break_det === 1'b1) brk_pulses++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!sample_tick) @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic send_bit(input logic v, input bit glitch);
    if (glitch) begin
      rx = v;  wait_ticks(8);
      rx = ~v; wait_ticks(1);
      rx = v;  wait_ticks(7);
    end else begin
      rx = v;  wait_ticks(16);
    end
  endtask

  task automatic do_pop();
    man_rd = 1'b1;
    @(negedge clk);
    man_rd = 1'b0;
  endtask

  // Stop bits are driven for samples 0..9 only, then the line idles high.
  task automatic send_frame(input logic [8:0] d, input int nb, input bit pen, input bit pval,
                            input bit s2, input bit st1, input bit st2, input bit glitch,
                            input bit pop_done);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < nb; i++) send_bit(d[i], glitch);
    if (pen) send_bit(pval, 1'b0);
    rx = st1; wait_ticks(10);
    if (!s2 && pop_done) do_pop();
    rx = 1'b1; wait_ticks(6);
    if (s2) begin
      rx = st2; wait_ticks(10);
      if (pop_done) do_pop();
      rx = 1'b1; wait_ticks(6);
    end
    rx = 1'b1; wait_ticks(4);
  endtask

  task automatic set_cfg(input int nb, input bit pen, input bit odd, input bit s2);
    cfg_data_bits  = 4'(nb);
    cfg_parity_en  = pen;
    cfg_parity_odd = odd;
    cfg_stop2      = s2;
  endtask

  task automatic expect_entry(input bit f, input bit p, input logic [8:0] d);
    exp_q.push_back({f, p, d});
  endtask

  task automatic drain(input string name);
    int n;
    auto_read = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk({name, "_pending"}, exp_q.size(), 0);
    chk({name, "_count"}, fifo_count, 0);
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; err_clr = 1'b0;
    set_cfg(8, 0, 0, 0);
    repeat (5) @(negedge clk);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_perr", rd_perr, 0);
    chk("rst_rd_ferr", rd_ferr, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_break_det", break_det, 0);
    chk("rst_perr_cnt", perr_cnt, 0);
    chk("rst_ferr_cnt", ferr_cnt, 0);
    chk("rst_ovf_cnt", ovf_cnt, 0);
    rst = 1'b0;
    wait_ticks(20);

    // 8N1, two bytes held then drained in order
    expect_entry(0, 0, 9'h055);
    expect_entry(0, 0, 9'h0A3);
    send_frame(9'h055, 8, 0, 0, 0, 1, 1, 0, 0);
    send_frame(9'h0A3, 8, 0, 0, 0, 1, 1, 0, 0);
    chk("8n1_count2", fifo_count, 2);
    drain("8n1");

    // 7E1, 0x41 has two ones so even parity bit is 0; send 1
    set_cfg(7, 1, 0, 0);
    expect_entry(0, 1, 9'h041);
    send_frame(9'h041, 7, 1, 1, 0, 1, 1, 0, 0);
    drain("7e1");
    chk("7e1_perr_cnt", perr_cnt, 1);

    // 8N2, bad second stop then a clean frame
    set_cfg(8, 0, 0, 1);
    expect_entry(1, 0, 9'h03C);
    expect_entry(0, 0, 9'h081);
    send_frame(9'h03C, 8, 0, 0, 1, 1, 0, 0, 0);
    send_frame(9'h081, 8, 0, 0, 1, 1, 1, 0, 0);
    drain("8n2");
    chk("8n2_ferr_cnt", ferr_cnt, 1);
    chk("8n2_perr_cnt", perr_cnt, 1);

    // Short start pulse rejected, then a normal frame
    set_cfg(8, 0, 0, 0);
    rx = 1'b0; wait_ticks(3);
    rx = 1'b1; wait_ticks(40);
    chk("glitch_start_count", fifo_count, 0);
    expect_entry(0, 0, 9'h05A);
    send_frame(9'h05A, 8, 0, 0, 0, 1, 1, 0, 0);
    drain("after_glitch");

    // Majority vote with a one-tick glitch at sample M in every data bit
    expect_entry(0, 0, 9'h0F0);
    send_frame(9'h0F0, 8, 0, 0, 0, 1, 1, 1, 0);
    drain("majority");

    // Break: line low for two frame times
    base = brk_pulses;
    rx = 1'b0; wait_ticks(320);
    rx = 1'b1; wait_ticks(40);
    chk("break_pulses", brk_pulses - base, 1);
    chk("break_count", fifo_count, 0);
    chk("break_perr_cnt", perr_cnt, 1);
    chk("break_ferr_cnt", ferr_cnt, 1);
    chk("break_ovf_cnt", ovf_cnt, 0);
    expect_entry(0, 0, 9'h033);
    send_frame(9'h033, 8, 0, 0, 0, 1, 1, 0, 0);
    drain("after_break");

    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    chk("clr_perr_cnt", perr_cnt, 0);
    chk("clr_ferr_cnt", ferr_cnt, 0);

    // Fill, overflow, then push coincident with pop while full
    auto_read = 1'b0;
    for (int i = 0; i < 16; i++) begin
      expect_entry(0, 0, 9'(8'h10 + i));
      send_frame(9'(8'h10 + i), 8, 0, 0, 0, 1, 1, 0, 0);
    end
    chk("fill_count", fifo_count, 16);
    base = ovf_pulses;
    send_frame(9'h0EE, 8, 0, 0, 0, 1, 1, 0, 0);
    chk("ovf_pulses", ovf_pulses - base, 1);
    chk("ovf_cnt", ovf_cnt, 1);
    chk("ovf_count", fifo_count, 16);
    expect_entry(0, 0, 9'h0AB);
    send_frame(9'h0AB, 8, 0, 0, 0, 1, 1, 0, 1);
    chk("pushpop_count", fifo_count, 16);
    chk("pushpop_no_ovf", ovf_pulses - base, 1);
    chk("pushpop_ovf_cnt", ovf_cnt, 1);
    drain("full_drain");

    // Reset in the middle of a data field
    auto_read = 1'b0;
    expect_entry(0, 0, 9'h011);
    send_frame(9'h011, 8, 0, 0, 0, 1, 1, 0, 0);
    chk("prerst_count", fifo_count, 1);
    rx = 1'b0; wait_ticks(16);
    rx = 1'b1; wait_ticks(16);
    rx = 1'b0; wait_ticks(5);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rx = 1'b1;
    chk("midrst_rd_valid", rd_valid, 0);
    chk("midrst_rd_data", rd_data, 0);
    chk("midrst_count", fifo_count, 0);
    chk("midrst_ovf_cnt", ovf_cnt, 0);
    chk("midrst_break_det", break_det, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_ticks(20);
    expect_entry(0, 0, 9'h0C7);
    send_frame(9'h0C7, 8, 0, 0, 0, 1, 1, 0, 0);
    drain("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
